// File: rtl/bt_hdr_pkg.sv
// Shared constants for the Bluetooth access-code / header sequencer.
// Holds state encodings, HEC polynomial, access-code lengths and header field offsets.
package bt_hdr_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PRE  = 3'd1;
  localparam state_t ST_SYNC = 3'd2;
  localparam state_t ST_TRL  = 3'd3;
  localparam state_t ST_HDR  = 3'd4;
  localparam state_t ST_DONE = 3'd5;

  localparam logic [7:0] HEC_POLY = 8'hA7;
  localparam int PRE_LEN = 4;
  localparam int TRL_LEN = 4;
  localparam int TYPE_W  = 4;

  // Header fields are packed LSB first: LT_ADDR, TYPE, FLOW, ARQN, SEQN
  function automatic int ofs_type(input int lt_w);
    return lt_w;
  endfunction

  function automatic int ofs_flow(input int lt_w);
    return lt_w + TYPE_W;
  endfunction

  function automatic int ofs_arqn(input int lt_w);
    return lt_w + TYPE_W + 1;
  endfunction

  function automatic int ofs_seqn(input int lt_w);
    return lt_w + TYPE_W + 2;
  endfunction

endpackage

// File: rtl/bt_hec_lfsr.sv
// Bit-serial HEC generator/checker shared by the TX and RX header paths.
// rem_nxt exposes the post-shift value so the final check can be registered on the last tick.
module bt_hec_lfsr
  import bt_hdr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_6M,
  input  logic         rstz,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] rem,
  output logic [W-1:0] rem_nxt
);

  logic fb;

  always_comb begin
    fb      = din ^ rem[W-1];
    rem_nxt = {rem[W-2:0], 1'b0} ^ (fb ? W'(HEC_POLY) : '0);
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      rem <= '0;
    end else if (load) begin
      rem <= load_val;
    end else if (shift) begin
      rem <= rem_nxt;
    end
  end

endmodule

// File: rtl/bt_hdr_seq.sv
// Access-code / packet-header sequencer: TX preamble, sync, trailer and FEC header,
// RX majority-vote header decode with HEC check and per-LT SEQN duplicate detection.
module bt_hdr_seq
  import bt_hdr_pkg::*;
#(
  parameter int SYNC_LEN = 64,
  parameter int HDR_BITS = 10,
  parameter int HEC_BITS = 8,
  parameter int FEC_REP  = 3,
  parameter int NUM_LT   = 8,
  parameter int LT_W     = 3
) (
  input  logic                clk_6M,
  input  logic                rstz,
  input  logic                p_1us,
  input  logic                tx_start_p,
  input  logic                tx_id_only,
  input  logic                rx_start_p,
  input  logic                abort,
  input  logic [SYNC_LEN-1:0] sync_word,
  input  logic [7:0]          uap,
  input  logic [LT_W-1:0]     tx_lt_addr,
  input  logic [3:0]          tx_type,
  input  logic                tx_flow,
  input  logic                tx_arqn,
  input  logic                tx_seqn,
  input  logic [LT_W-1:0]     my_lt_addr,
  input  logic                whiten_bit,
  input  logic                rxbit,
  output logic                txbit,
  output logic                tx_active,
  output logic                whiten_step,
  output logic                hdr_done_p,
  output logic [LT_W-1:0]     dec_lt_addr,
  output logic [3:0]          dec_type,
  output logic [NUM_LT-1:0]   dec_flow,
  output logic [NUM_LT-1:0]   dec_arqn,
  output logic                dec_seqn,
  output logic                dec_hecgood,
  output logic                lt_addressed,
  output logic                rx_dup
);

  localparam int HDR_TOT = HDR_BITS + HEC_BITS;
  localparam int CNT_W   = $clog2(SYNC_LEN + HDR_TOT + 1);
  localparam int SYNC_IW = $clog2(SYNC_LEN);
  localparam int HDR_IW  = $clog2(HDR_BITS);
  localparam int REP_W   = (FEC_REP > 1) ? $clog2(FEC_REP) : 1;
  localparam int ONES_W  = $clog2(FEC_REP + 1);

  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0]  SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0]  TRL_LAST  = CNT_W'(TRL_LEN - 1);
  localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(HDR_TOT - 1);
  localparam logic [CNT_W-1:0]  C_DATA    = CNT_W'(HDR_BITS);
  localparam logic [CNT_W-1:0]  C_FLOW    = CNT_W'(ofs_flow(LT_W));
  localparam logic [CNT_W-1:0]  C_ARQN    = CNT_W'(ofs_arqn(LT_W));
  localparam logic [CNT_W-1:0]  C_SEQN    = CNT_W'(ofs_seqn(LT_W));
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(FEC_REP - 1);
  localparam logic [ONES_W-1:0] MAJ       = ONES_W'(FEC_REP / 2);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [REP_W-1:0]    rep;
  logic [ONES_W-1:0]   ones;
  logic                is_tx;
  logic                id_only;
  logic [NUM_LT-1:0]   last_seqn;
  logic [HEC_BITS-1:0] rem;
  logic [HEC_BITS-1:0] rem_nxt;
  logic [HDR_BITS-1:0] hdr_vec;
  logic                tx_bit_log;
  logic                rx_chip;
  logic                rx_dec;
  logic                grp_end;
  logic                hec_load;
  logic                hec_shift;
  logic                hec_din;
  logic                hec_ok;

  assign hdr_vec = {tx_seqn, tx_arqn, tx_flow, tx_type, tx_lt_addr};

  // Preamble alternates starting with sync_word[0]; trailer starts with ~sync_word[MSB]
  always_comb begin
    tx_bit_log = 1'b0;
    case (state)
      ST_PRE:  tx_bit_log = sync_word[0] ^ cnt[0];
      ST_SYNC: tx_bit_log = sync_word[cnt[SYNC_IW-1:0]];
      ST_TRL:  tx_bit_log = ~sync_word[SYNC_LEN-1] ^ cnt[0];
      ST_HDR:  tx_bit_log = (cnt < C_DATA) ? hdr_vec[cnt[HDR_IW-1:0]] : rem[HEC_BITS-1];
      default: tx_bit_log = 1'b0;
    endcase
  end

  assign tx_active   = is_tx && (state == ST_PRE || state == ST_SYNC ||
                                 state == ST_TRL || state == ST_HDR);
  assign txbit       = tx_active && !abort && (tx_bit_log ^ ((state == ST_HDR) && whiten_bit));
  assign grp_end     = p_1us && (state == ST_HDR) && (rep == REP_LAST);
  assign whiten_step = grp_end && !abort;
  assign hdr_done_p  = (state == ST_DONE) && !abort;

  assign rx_chip   = rxbit ^ whiten_bit;
  assign rx_dec    = (ones + ONES_W'(rx_chip)) > MAJ;
  assign hec_din   = is_tx ? tx_bit_log : rx_dec;
  assign hec_shift = grp_end && !abort;
  assign hec_load  = p_1us && !abort &&
                     ((state == ST_TRL && cnt == TRL_LAST) ||
                      (state == ST_IDLE && rx_start_p && !tx_start_p));
  assign hec_ok    = (rem_nxt == '0);

  bt_hec_lfsr #(.W(HEC_BITS)) u_hec (
    .clk_6M   (clk_6M),
    .rstz     (rstz),
    .load     (hec_load),
    .load_val (HEC_BITS'(uap)),
    .shift    (hec_shift),
    .din      (hec_din),
    .rem      (rem),
    .rem_nxt  (rem_nxt)
  );

  always_ff @(posedge clk_6M) begin
    if (!rstz || abort) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rep     <= '0;
      ones    <= '0;
      is_tx   <= 1'b0;
      id_only <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (p_1us && tx_start_p) begin
            state   <= ST_PRE;
            is_tx   <= 1'b1;
            id_only <= tx_id_only;
            cnt     <= '0;
          end else if (p_1us && rx_start_p) begin
            state <= ST_HDR;
            is_tx <= 1'b0;
            cnt   <= '0;
            rep   <= '0;
            ones  <= '0;
          end
        end
        ST_PRE: begin
          if (p_1us) begin
            if (cnt == PRE_LAST) begin
              state <= ST_SYNC;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_SYNC: begin
          if (p_1us) begin
            if (cnt == SYNC_LAST) begin
              state <= id_only ? ST_DONE : ST_TRL;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_TRL: begin
          if (p_1us) begin
            if (cnt == TRL_LAST) begin
              state <= ST_HDR;
              cnt   <= '0;
              rep   <= '0;
              ones  <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HDR: begin
          if (p_1us) begin
            if (rep == REP_LAST) begin
              rep  <= '0;
              ones <= '0;
              if (cnt == HDR_LAST) begin
                state <= ST_DONE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              rep  <= rep + 1'b1;
              ones <= ones + ONES_W'(rx_chip);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          is_tx <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Fields land as each group is voted; flow/arqn index the LT decoded earlier in the header
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      dec_lt_addr  <= '0;
      dec_type     <= '0;
      dec_flow     <= '0;
      dec_arqn     <= '0;
      dec_seqn     <= 1'b0;
      dec_hecgood  <= 1'b0;
      lt_addressed <= 1'b0;
      rx_dup       <= 1'b0;
      last_seqn    <= '1;
    end else if (grp_end && !abort && !is_tx) begin
      for (int i = 0; i < LT_W; i++) begin
        if (cnt == CNT_W'(i)) dec_lt_addr[i] <= rx_dec;
      end
      for (int i = 0; i < TYPE_W; i++) begin
        if (cnt == CNT_W'(ofs_type(LT_W) + i)) dec_type[i] <= rx_dec;
      end
      if (cnt == C_FLOW) dec_flow[dec_lt_addr] <= rx_dec;
      if (cnt == C_ARQN) dec_arqn[dec_lt_addr] <= rx_dec;
      if (cnt == C_SEQN) dec_seqn <= rx_dec;
      if (cnt == HDR_LAST) begin
        dec_hecgood  <= hec_ok;
        lt_addressed <= hec_ok && (dec_lt_addr == my_lt_addr);
        rx_dup       <= hec_ok && (dec_seqn == last_seqn[dec_lt_addr]);
        if (hec_ok && (dec_seqn != last_seqn[dec_lt_addr])) begin
          last_seqn[dec_lt_addr] <= dec_seqn;
        end
      end
    end
  end

endmodule

// File: tb/tb_bt_hdr_seq.sv
// Self-checking bench for bt_hdr_seq: TX bit streams and RX decode against a frame-level model.
// Stimulus is randomized; expected streams and decodes are built from whole-frame arithmetic.
module tb_bt_hdr_seq;

  localparam int SYNC_LEN = 64;
  localparam int HDR_BITS = 10;
  localparam int HEC_BITS = 8;
  localparam int FEC_REP  = 3;
  localparam int NUM_LT   = 8;
  localparam int LT_W     = 3;
  localparam int NGRP     = HDR_BITS + HEC_BITS;
  localparam int NCHIP    = NGRP * FEC_REP;

  logic                clk_6M = 1'b0;
  logic                rstz = 1'b0;
  logic                p_1us = 1'b0;
  logic                tx_start_p = 1'b0;
  logic                tx_id_only = 1'b0;
  logic                rx_start_p = 1'b0;
  logic                abort = 1'b0;
  logic [SYNC_LEN-1:0] sync_word = '0;
  logic [7:0]          uap = '0;
  logic [LT_W-1:0]     tx_lt_addr = '0;
  logic [3:0]          tx_type = '0;
  logic                tx_flow = 1'b0;
  logic                tx_arqn = 1'b0;
  logic                tx_seqn = 1'b0;
  logic [LT_W-1:0]     my_lt_addr = '0;
  logic                whiten_bit = 1'b0;
  logic                rxbit = 1'b0;
  logic                txbit, tx_active, whiten_step, hdr_done_p;
  logic [LT_W-1:0]     dec_lt_addr;
  logic [3:0]          dec_type;
  logic [NUM_LT-1:0]   dec_flow, dec_arqn;
  logic                dec_seqn, dec_hecgood, lt_addressed, rx_dup;

  int n_vec = 0;
  int n_err = 0;
  logic ws_s;

  logic [NUM_LT-1:0] m_flow, m_arqn, m_last;
  logic [LT_W-1:0]   m_lt;
  logic [3:0]        m_type;
  logic              m_seqn, m_good, m_addr, m_dup;

  bt_hdr_seq dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .tx_start_p(tx_start_p),
    .tx_id_only(tx_id_only), .rx_start_p(rx_start_p), .abort(abort),
    .sync_word(sync_word), .uap(uap), .tx_lt_addr(tx_lt_addr), .tx_type(tx_type),
    .tx_flow(tx_flow), .tx_arqn(tx_arqn), .tx_seqn(tx_seqn), .my_lt_addr(my_lt_addr),
    .whiten_bit(whiten_bit), .rxbit(rxbit), .txbit(txbit), .tx_active(tx_active),
    .whiten_step(whiten_step), .hdr_done_p(hdr_done_p), .dec_lt_addr(dec_lt_addr),
    .dec_type(dec_type), .dec_flow(dec_flow), .dec_arqn(dec_arqn), .dec_seqn(dec_seqn),
    .dec_hecgood(dec_hecgood), .lt_addressed(lt_addressed), .rx_dup(rx_dup)
  );

  always #5 clk_6M = ~clk_6M;

  function automatic logic [7:0] hec_of(input logic [7:0] u, input logic [HDR_BITS-1:0] d);
    logic [7:0] r;
    r = u;
    for (int i = 0; i < HDR_BITS; i++) begin
      if (d[i] ^ r[7]) r = {r[6:0], 1'b0} ^ 8'hA7;
      else             r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // Logical header: 10 field bits then HEC sent MSB first
  function automatic logic [NGRP-1:0] logical_hdr(input logic [7:0] u, input logic [HDR_BITS-1:0] d);
    logic [NGRP-1:0] lg;
    logic [7:0] h;
    h = hec_of(u, d);
    lg[HDR_BITS-1:0] = d;
    for (int j = 0; j < HEC_BITS; j++) lg[HDR_BITS+j] = h[7-j];
    return lg;
  endfunction

  task automatic tick();
    repeat (5) @(negedge clk_6M);
    p_1us = 1'b1;
    #1 ws_s = whiten_step;
    @(negedge clk_6M);
    p_1us = 1'b0;
    tx_start_p = 1'b0;
    rx_start_p = 1'b0;
  endtask

  task automatic model_reset();
    m_flow = '0; m_arqn = '0; m_last = '1; m_lt = '0; m_type = '0;
    m_seqn = 1'b0; m_good = 1'b0; m_addr = 1'b0; m_dup = 1'b0;
  endtask

  task automatic test_reset();
    rstz = 1'b0;
    repeat (3) @(negedge clk_6M);
    rstz = 1'b1;
    model_reset();
    @(negedge clk_6M);
    n_vec++;
    if ({txbit, tx_active, whiten_step, hdr_done_p, dec_lt_addr, dec_type, dec_flow, dec_arqn,
         dec_seqn, dec_hecgood, lt_addressed, rx_dup} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got txbit=%b act=%b lt=%h type=%h flow=%h arqn=%h good=%b, want all 0",
               txbit, tx_active, dec_lt_addr, dec_type, dec_flow, dec_arqn, dec_hecgood);
    end
  endtask

  task automatic tx_frame(input bit idonly, input bit zero_w, input bit noise);
    logic exp_q[$];
    int hk[$];
    logic [NGRP-1:0] lg, w;
    logic exp_ws;
    int n, pulses, exp_pulses;
    lg = logical_hdr(uap, {tx_seqn, tx_arqn, tx_flow, tx_type, tx_lt_addr});
    w = zero_w ? '0 : NGRP'({$urandom, $urandom});
    for (int i = 0; i < 4; i++) begin exp_q.push_back((i % 2 == 0) ? sync_word[0] : ~sync_word[0]); hk.push_back(-1); end
    for (int i = 0; i < SYNC_LEN; i++) begin exp_q.push_back(sync_word[i]); hk.push_back(-1); end
    if (!idonly) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back((i % 2 == 0) ? ~sync_word[SYNC_LEN-1] : sync_word[SYNC_LEN-1]); hk.push_back(-1);
      end
      for (int k = 0; k < NGRP; k++)
        for (int r = 0; r < FEC_REP; r++) begin exp_q.push_back(lg[k] ^ w[k]); hk.push_back(k*FEC_REP + r); end
    end
    n = exp_q.size();
    pulses = 0;
    exp_pulses = idonly ? 0 : NGRP;
    for (int s = 0; s <= n; s++) begin
      if (s == 0) begin tx_start_p = 1'b1; tx_id_only = idonly; end
      if (noise && s == 10) begin tx_start_p = 1'b1; rx_start_p = 1'b1; end
      tick();
      exp_ws = (s > 0) && (hk[s-1] >= 0) && (hk[s-1] % FEC_REP == FEC_REP - 1);
      if (ws_s) pulses++;
      n_vec++;
      if (ws_s !== exp_ws) begin
        n_err++;
        $display("FAIL tx_whiten_step tick %0d: got %b want %b", s, ws_s, exp_ws);
      end
      if (s < n) begin
        whiten_bit = (hk[s] >= 0) ? w[hk[s] / FEC_REP] : 1'($urandom);
        #1;
        n_vec++;
        if ({txbit, tx_active, hdr_done_p} !== {exp_q[s], 1'b1, 1'b0}) begin
          n_err++;
          $display("FAIL tx_bit tick %0d: got txbit/act/done=%b%b%b want %b10",
                   s, txbit, tx_active, hdr_done_p, exp_q[s]);
        end
      end else begin
        n_vec++;
        if ({txbit, tx_active, hdr_done_p} !== 3'b001) begin
          n_err++;
          $display("FAIL tx_done tick %0d: got txbit/act/done=%b%b%b want 001", s, txbit, tx_active, hdr_done_p);
        end
      end
    end
    @(negedge clk_6M);
    n_vec++;
    if (hdr_done_p !== 1'b0 || pulses != exp_pulses) begin
      n_err++;
      $display("FAIL tx_after_done: got done=%b pulses=%0d want done=0 pulses=%0d", hdr_done_p, pulses, exp_pulses);
    end
    tx_id_only = 1'b0;
    whiten_bit = 1'b0;
  endtask

  // flips: 0 clean, 1 one flipped chip per group, 2 two flipped chips in one group
  task automatic rx_frame(input logic [LT_W-1:0] lt, input logic [3:0] ty, input logic fl, input logic ar,
                          input logic sq, input int flips, input int abort_at);
    logic [NGRP-1:0] lg, w, dk;
    logic [NCHIP-1:0] chip;
    logic [HDR_BITS-1:0] dd;
    logic [7:0] hh;
    int bad_g, p, ones, seen_done;
    logic good;
    lg = logical_hdr(uap, {sq, ar, fl, ty, lt});
    w = NGRP'({$urandom, $urandom});
    bad_g = $urandom_range(0, NGRP-1);
    for (int k = 0; k < NGRP; k++) begin
      p = $urandom_range(0, FEC_REP-1);
      for (int r = 0; r < FEC_REP; r++) begin
        chip[k*FEC_REP + r] = lg[k] ^ w[k] ^ ((flips == 1 && r == p) || (flips == 2 && k == bad_g && r < 2));
      end
    end
    rx_start_p = 1'b1;
    tick();
    seen_done = 0;
    for (int j = 0; j < NCHIP; j++) begin
      if (j == abort_at) begin
        @(negedge clk_6M) abort = 1'b1;
        @(negedge clk_6M) abort = 1'b0;
        for (int t = 0; t < NCHIP + 4; t++) begin
          rxbit = 1'($urandom);
          tick();
          if (hdr_done_p) seen_done++;
        end
        n_vec++;
        if (seen_done != 0 || {dec_hecgood, lt_addressed, rx_dup} !== {m_good, m_addr, m_dup}) begin
          n_err++;
          $display("FAIL rx_abort: got done_pulses=%0d good/addr/dup=%b%b%b want 0 %b%b%b",
                   seen_done, dec_hecgood, lt_addressed, rx_dup, m_good, m_addr, m_dup);
        end
        return;
      end
      rxbit = chip[j];
      whiten_bit = w[j / FEC_REP];
      tick();
      if (j < NCHIP - 1 && hdr_done_p) seen_done++;
    end
    for (int k = 0; k < NGRP; k++) begin
      ones = 0;
      for (int r = 0; r < FEC_REP; r++) ones += int'(chip[k*FEC_REP + r] ^ w[k]);
      dk[k] = (ones > FEC_REP / 2);
    end
    dd = dk[HDR_BITS-1:0];
    hh = hec_of(uap, dd);
    good = 1'b1;
    for (int j = 0; j < HEC_BITS; j++) if (dk[HDR_BITS+j] != hh[7-j]) good = 1'b0;
    m_lt = dd[LT_W-1:0];
    m_type = dd[LT_W+3:LT_W];
    m_flow[m_lt] = dd[LT_W+4];
    m_arqn[m_lt] = dd[LT_W+5];
    m_seqn = dd[LT_W+6];
    m_good = good;
    m_addr = good && (m_lt == my_lt_addr);
    m_dup = good && (m_seqn == m_last[m_lt]);
    if (good) m_last[m_lt] = m_seqn;
    n_vec++;
    if (hdr_done_p !== 1'b1 || seen_done != 0) begin
      n_err++;
      $display("FAIL rx_done_pulse: got done=%b early=%0d want done=1 early=0", hdr_done_p, seen_done);
    end
    n_vec++;
    if ({dec_lt_addr, dec_type, dec_seqn} !== {m_lt, m_type, m_seqn}) begin
      n_err++;
      $display("FAIL rx_fields: got lt=%0d type=%h seqn=%b want lt=%0d type=%h seqn=%b",
               dec_lt_addr, dec_type, dec_seqn, m_lt, m_type, m_seqn);
    end
    n_vec++;
    if ({dec_flow, dec_arqn} !== {m_flow, m_arqn}) begin
      n_err++;
      $display("FAIL rx_flow_arqn: got flow=%h arqn=%h want flow=%h arqn=%h", dec_flow, dec_arqn, m_flow, m_arqn);
    end
    n_vec++;
    if ({dec_hecgood, lt_addressed, rx_dup} !== {m_good, m_addr, m_dup}) begin
      n_err++;
      $display("FAIL rx_status: got good/addr/dup=%b%b%b want %b%b%b",
               dec_hecgood, lt_addressed, rx_dup, m_good, m_addr, m_dup);
    end
    @(negedge clk_6M);
    n_vec++;
    if (hdr_done_p !== 1'b0) begin
      n_err++;
      $display("FAIL rx_done_width: got done=%b want 0", hdr_done_p);
    end
    whiten_bit = 1'b0;
  endtask

  task automatic test_tx_plain();
    sync_word = {1'b0, 62'($urandom) << 30 ^ 62'($urandom), 1'b1};
    {tx_lt_addr, tx_type, tx_flow, tx_arqn, tx_seqn} = '0;
    uap = 8'h00;
    tx_frame(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_tx_id();
    sync_word = {$urandom, $urandom};
    tx_frame(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_tx_random();
    for (int i = 0; i < 3; i++) begin
      sync_word = {$urandom, $urandom};
      uap = 8'($urandom);
      {tx_lt_addr, tx_type, tx_flow, tx_arqn, tx_seqn} = 10'($urandom);
      tx_frame(1'b0, 1'b0, i == 1);
    end
  endtask

  task automatic test_rx_loopback();
    uap = 8'h47;
    my_lt_addr = 3'd3;
    rx_frame(3'd3, 4'b0001, 1'b1, 1'b1, 1'b0, 0, -1);
  endtask

  task automatic test_rx_flips();
    uap = 8'h47;
    rx_frame(3'd3, 4'b0001, 1'b1, 1'b0, 1'b1, 1, -1);
    rx_frame(3'd3, 4'b1010, 1'b0, 1'b1, 1'b0, 2, -1);
    rx_frame(3'd3, 4'b1010, 1'b0, 1'b1, 1'b0, 0, -1);
  endtask

  task automatic test_dup();
    uap = 8'($urandom);
    my_lt_addr = 3'd2;
    rx_frame(3'd2, 4'h4, 1'b0, 1'b0, 1'b0, 0, -1);
    rx_frame(3'd2, 4'h4, 1'b0, 1'b0, 1'b0, 1, -1);
    rx_frame(3'd2, 4'h4, 1'b1, 1'b0, 1'b1, 0, -1);
  endtask

  task automatic test_abort();
    uap = 8'($urandom);
    rx_frame(3'd5, 4'h9, 1'b1, 1'b1, 1'b1, 0, $urandom_range(4, 20));
    rx_frame(3'd5, 4'h9, 1'b1, 1'b1, 1'b1, 0, -1);
  endtask

  task automatic test_reset_mid_sync();
    sync_word = {$urandom, $urandom};
    tx_start_p = 1'b1;
    tick();
    repeat (20) tick();
    rstz = 1'b0;
    @(negedge clk_6M);
    model_reset();
    n_vec++;
    if ({txbit, tx_active, whiten_step, hdr_done_p, dec_lt_addr, dec_type, dec_flow, dec_arqn,
         dec_seqn, dec_hecgood, lt_addressed, rx_dup} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_sync: got txbit=%b act=%b flow=%h arqn=%h good=%b dup=%b, want all 0",
               txbit, tx_active, dec_flow, dec_arqn, dec_hecgood, rx_dup);
    end
    rstz = 1'b1;
    @(negedge clk_6M);
  endtask

  task automatic test_rx_random();
    for (int i = 0; i < 6; i++) begin
      uap = 8'($urandom);
      my_lt_addr = 3'($urandom);
      rx_frame(3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 1), -1);
    end
  endtask

  initial begin
    test_reset();
    test_tx_plain();
    test_tx_id();
    test_tx_random();
    test_rx_loopback();
    test_rx_flips();
    test_dup();
    test_abort();
    test_reset_mid_sync();
    test_dup();
    test_rx_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bt_hdr_seq.md
Name: bt_hdr_seq

Overview:
- Parametrised successor to the header bit processor: one engine serialises the TX access code and packet header, and deserialises the RX header.
- TX access code: preamble, sync word, optional trailer. TX header: rate-1/N repetition FEC with HEC generation.
- RX header path: repetition FEC majority-vote decode, HEC check, field extraction.
- Adds per-LT SEQN duplicate detection, configurable FEC repetition, and abort. Sits between link control (slot/mode logic) and the bit-level modem/whitening path; all bit timing is on the p_1us tick.

Parameters:
- SYNC_LEN, 64, sync word length in bits.
- HDR_BITS, 10, header payload bits: LT_ADDR(LT_W), TYPE(4), FLOW, ARQN, SEQN, LSB first.
- HEC_BITS, 8, HEC length; generator polynomial 0xA7.
- FEC_REP, 3, repetition factor; odd, at least 1.
- NUM_LT, 8, number of logical transports tracked.
- LT_W, 3, LT_ADDR width; NUM_LT must equal 2^LT_W.

Ports:
- clk_6M  in  1  system clock
- rstz  in  1  synchronous active-low reset
- p_1us  in  1  one-clock bit tick, once per microsecond
- tx_start_p  in  1  start TX access code, sampled with p_1us
- tx_id_only  in  1  ID packet (access code only, no trailer/header), sampled at tx_start_p
- rx_start_p  in  1  RX trailer end seen; next tick carries header bit 0
- abort  in  1  force IDLE
- sync_word  in  SYNC_LEN  sync word, bit 0 sent first
- uap  in  8  HEC initial value
- tx_lt_addr  in  LT_W  TX header field
- tx_type  in  4  TX header field
- tx_flow, tx_arqn, tx_seqn  in  1 each  TX header fields
- my_lt_addr  in  LT_W  local address used for lt_addressed
- whiten_bit  in  1  whitening bit XORed onto header bits, TX and RX
- rxbit  in  1  received demodulated bit, valid at p_1us
- txbit  out  1  serial TX bit
- tx_active  out  1  high while TX engine is busy
- whiten_step  out  1  one-clock strobe that advances the external whitening LFSR
- hdr_done_p  out  1  one-clock pulse at header end; same pulse as payload start
- dec_lt_addr  out  LT_W  decoded header field
- dec_type  out  4  decoded header field
- dec_flow, dec_arqn  out  NUM_LT  per-LT decoded bits
- dec_seqn  out  1  decoded SEQN
- dec_hecgood  out  1  HEC check result
- lt_addressed  out  1  good HEC and dec_lt_addr==my_lt_addr
- rx_dup  out  1  SEQN equals last accepted SEQN for this LT

Behaviour:
- Reset (rstz low at a clk_6M edge):
  - FSM to IDLE; all outputs 0.
  - Per-LT last_seqn array set to 1, so the first SEQN=0 packet is not a duplicate.
- FSM states: IDLE, PRE, SYNC, TRL, HDR, DONE. The bit counter advances only on p_1us.
  - IDLE -> PRE on tx_start_p&p_1us.
  - IDLE -> HDR on rx_start_p&p_1us; RX header bits then start on the next tick.
  - PRE: 4 bits. Pattern 1010 (first-sent first) when sync_word[0]==1, else 0101.
  - SYNC: SYNC_LEN bits, sync_word[0] first.
  - SYNC -> DONE if tx_id_only, else -> TRL.
  - TRL: 4 bits. Pattern 0101 when sync_word[SYNC_LEN-1]==1, else 1010.
  - HDR: (HDR_BITS+HEC_BITS)*FEC_REP ticks.
  - DONE: hdr_done_p asserted for exactly one clk_6M cycle, then -> IDLE.
- TX header:
  - Logical bit k is sent FEC_REP consecutive times.
  - Bits 0..HDR_BITS-1 come from the fields. The HEC LFSR is loaded with uap on HDR entry. Per data bit: fb=d^r[7]; r={r[6:0],0}^(fb?0xA7:0).
  - Bits HDR_BITS..end send r[7], then shift in 0.
  - txbit = logical bit ^ whiten_bit.
  - whiten_step pulses on the tick of the last repetition of each logical bit.
- RX header:
  - Per group, count ones in rxbit^whiten_bit. Decoded bit = (ones > FEC_REP/2). The count clears each group.
  - Each decoded bit feeds the same LFSR, data bits and HEC bits alike.
  - Fields shift in LSB first. dec_flow[lt] and dec_arqn[lt] are written only at their bit positions, indexed by the already-decoded LT_ADDR.
- At RX DONE, registered and valid with hdr_done_p:
  - dec_hecgood = (r==0).
  - lt_addressed = hecgood & (dec_lt_addr==my_lt_addr).
  - rx_dup = hecgood & (dec_seqn==last_seqn[lt]).
  - If hecgood and not rx_dup: last_seqn[lt] <= dec_seqn.
- A failed HEC leaves last_seqn and the prior dec_flow/dec_arqn of other LTs untouched. The current LT's flow/arqn bits are overwritten, matching the existing block.
- Simultaneous events:
  - tx_start_p and rx_start_p on the same tick: TX wins.
  - Either start outside IDLE is ignored.
- abort: in any state, -> IDLE next clock. hdr_done_p is not generated; decoded registers keep their values; txbit=0.
- txbit=0 and tx_active=0 outside TX states.

Decomposition:
- Shared package bt_hdr_pkg holds: state enum, HEC_POLY=8'hA7, PRE_LEN=4, TRL_LEN=4, header field bit offsets.
- One sub-module, bt_hec_lfsr: load/shift/bit inputs, remainder output. Used for both TX and RX.

Test Plan:
- TX non-ID, sync_word[0]=1, sync_word[63]=0, header fields all 0, uap=0x00, whiten_bit=0 -> txbit sequence 1010, then sync LSB-first, then 1010, then 54 zeros; hdr_done_p at tick 4+64+4+54.
- TX tx_id_only=1 -> 68 bits, hdr_done_p one cycle after sync bit 63, no whiten_step pulses.
- RX loopback: TX header lt=3, type=0001, flow=1, arqn=1, seqn=0, uap=0x47 -> dec_lt_addr=3, dec_type=1, dec_flow[3]=1, dec_arqn[3]=1, dec_hecgood=1; lt_addressed=1 with my_lt_addr=3.
- RX with one flipped bit in every 3-bit group -> identical decode, dec_hecgood=1. Two flips in one group -> dec_hecgood=0, last_seqn unchanged.
- Same good header with seqn=0 received twice on lt=2 -> first rx_dup=0, second rx_dup=1. Then seqn=1 -> rx_dup=0.
- abort mid-HDR, then rx_start_p -> no hdr_done_p from the aborted frame; the new frame decodes correctly. rstz low mid-SYNC -> all outputs 0 next cycle.
